// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the skewing preload FIFO bank feeding a DIM x DIM systolic MAC array.
// Runs a K-tiled job: fetch, preload, one skewed wavefront per tile, then drain and done.
module systolic_feed_ctrl #(
  parameter int unsigned DIM     = 8,
  parameter int unsigned TILES_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TILES_W-1:0] num_tiles,
  output logic               busy,
  output logic               done,
  output logic               mem_rd,
  output logic [TILES_W-1:0] mem_tile,
  input  logic               mem_valid,
  output logic               fifo_wr,
  output logic               fifo_en,
  output logic               mac_clr
);

  localparam int unsigned CNT_W = $clog2(2 * DIM);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(2 * DIM - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TILES_W-1:0] tile_q, tile_d;
  logic [TILES_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_rd_q, mem_rd_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic               fifo_en_q, fifo_en_d;
  logic               mac_clr_q, mac_clr_d;

  // Next-state, counters, and next-cycle Moore outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = (num_tiles == '0) ? TILES_W'(1) : num_tiles;
          tile_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = SHIFT_LOAD;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (tile_q == count_q - TILES_W'(1)) begin
            cnt_d   = DRAIN_LOAD;
            state_d = S_DRAIN;
          end else begin
            tile_d  = tile_q + TILES_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    mem_rd_d  = (state_d == S_FETCH);
    fifo_wr_d = (state_d == S_LOAD);
    fifo_en_d = (state_d == S_SHIFT);
    mac_clr_d = (state_d == S_LOAD) && (tile_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tile_q    <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      fifo_wr_q <= 1'b0;
      fifo_en_q <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_rd_q  <= mem_rd_d;
      fifo_wr_q <= fifo_wr_d;
      fifo_en_q <= fifo_en_d;
      mac_clr_q <= mac_clr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_tile = tile_q;
  assign fifo_wr  = fifo_wr_q;
  assign fifo_en  = fifo_en_q;
  assign mac_clr  = mac_clr_q;

endmodule
